// File: rtl/ifetch_unit.sv
// Instruction fetch unit: drives insmem addresses, buffers fetched words with their PC
// in a prefetch FIFO, and hands them to decode over valid/ready. Optional counters: IFETCH_PERF_EN.
module ifetch_unit #(
  parameter int         DEPTH      = 4,
  parameter logic [5:0] RESET_ADDR = 6'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [5:0]  addr_code,
  input  logic [31:0] code,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_code,
  output logic [5:0]  ins_pc,
  input  logic        redirect_valid,
  input  logic [5:0]  redirect_addr,
  output logic [2:0]  fifo_count
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_flushed
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 4;

  typedef enum logic [1:0] {IDLE, RUN, STALL} fetch_state_t;

  fetch_state_t  fetch_state;
  logic [5:0]    pc_reg, pc_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          pop, push, not_full;

  logic [5:0]    pc_mem   [DEPTH];
  logic [31:0]   code_mem [DEPTH];

  // Fetch state is a pure function of the current inputs; no cycles are spent switching.
  always_comb begin
    pop         = (count_reg != '0) & ins_ready & ~redirect_valid;
    not_full    = count_reg < CW'(DEPTH);
    fetch_state = IDLE;
    if (fetch_en) begin
      fetch_state = (not_full | pop) ? RUN : STALL;
    end
    push        = (fetch_state == RUN) & ~redirect_valid;

    pc_next     = pc_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (redirect_valid) begin
      pc_next     = redirect_addr;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        pc_next     = pc_reg + 6'd1;
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg     <= RESET_ADDR;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      pc_reg     <= pc_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset: every read is qualified by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= pc_reg;
      code_mem[wr_ptr_reg] <= code;
    end
  end

  assign addr_code  = pc_reg;
  assign ins_valid  = (count_reg != '0);
  assign ins_code   = ins_valid ? code_mem[rd_ptr_reg] : 32'd0;
  assign ins_pc     = ins_valid ? pc_mem[rd_ptr_reg]   : 6'd0;
  // A full DEPTH=8 FIFO does not fit the 3-bit occupancy port, so it reads as 7.
  assign fifo_count = (count_reg > 4'd7) ? 3'd7 : count_reg[2:0];

`ifdef IFETCH_PERF_EN
  logic [15:0] perf_fetched_reg, perf_flushed_reg;
  logic [16:0] flushed_sum;

  assign flushed_sum = {1'b0, perf_flushed_reg} + 17'(count_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_reg <= '0;
      perf_flushed_reg <= '0;
    end else begin
      if (push && perf_fetched_reg != 16'hFFFF) begin
        perf_fetched_reg <= perf_fetched_reg + 16'd1;
      end
      if (redirect_valid) begin
        perf_flushed_reg <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
      end
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_flushed = perf_flushed_reg;
`endif

endmodule
